// File: rtl/bram_pkg.sv
// Shared types and helpers for the true-dual-port block RAM.
// Write-mode encoding and byte-lane count helper.
package bram_pkg;

    typedef enum logic [1:0] {
        READ_FIRST,
        WRITE_FIRST,
        NO_CHANGE
    } bram_wmode_e;

    function automatic int bram_nb(input int dw, input int bw);
        return dw / bw;
    endfunction

endpackage

// File: rtl/bram_port_out.sv
// Per-port read-out path: write-mode mux, valid strobe, optional
// output register, all output state cleared asynchronously.
module bram_port_out import bram_pkg::*; #(
    parameter int          DATA_WIDTH = 16,
    parameter int          BYTE_WIDTH = 8,
    parameter bram_wmode_e WRITE_MODE = READ_FIRST,
    parameter int          OUT_REG    = 0,
    localparam int         NB         = bram_nb(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NB-1:0]         we,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  val
);

    logic                  acc_q;
    logic [NB-1:0]         we_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic [DATA_WIDTH-1:0] w1;
    logic                  v1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= 1'b0;
            we_q  <= '0;
            din_q <= '0;
        end else begin
            acc_q <= en;
            we_q  <= en ? we : '0;
            din_q <= din;
        end
    end

    // q is the pre-write word; the mode decides what a write presents
    always_comb begin
        w1 = q;
        v1 = acc_q;
        if (|we_q) begin
            case (WRITE_MODE)
                WRITE_FIRST: begin
                    for (int i = 0; i < NB; i++) begin
                        if (we_q[i]) begin
                            w1[i*BYTE_WIDTH +: BYTE_WIDTH] =
                                din_q[i*BYTE_WIDTH +: BYTE_WIDTH];
                        end
                    end
                end
                NO_CHANGE: v1 = 1'b0;
                default:   ;
            endcase
        end
    end

    if (OUT_REG != 0) begin : g_reg
        logic [DATA_WIDTH-1:0] d2_q;
        logic                  v2_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                d2_q <= '0;
                v2_q <= 1'b0;
            end else begin
                v2_q <= v1;
                if (v1) d2_q <= w1;
            end
        end

        assign dout = d2_q;
        assign val  = v2_q;
    end else begin : g_comb
        logic [DATA_WIDTH-1:0] hold_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) hold_q <= '0;
            else if (v1) hold_q <= w1;
        end

        assign dout = v1 ? w1 : hold_q;
        assign val  = v1;
    end

endmodule

// File: rtl/bram_tdp.sv
// Single-clock true-dual-port block RAM with byte enables.
// Port A wins overlapping bytes when both ports write one address.
module bram_tdp import bram_pkg::*; #(
    parameter int          DATA_WIDTH = 16,
    parameter int          ADDR_WIDTH = 9,
    parameter int          BYTE_WIDTH = 8,
    parameter bram_wmode_e WRITE_MODE = READ_FIRST,
    parameter int          OUT_REG    = 0,
    localparam int         NB         = bram_nb(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  ena,
    input  logic [NB-1:0]         wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta,
    output logic                  vala,
    input  logic                  enb,
    input  logic [NB-1:0]         web,
    input  logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] dinb,
    output logic [DATA_WIDTH-1:0] doutb,
    output logic                  valb
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_chk
        $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] qa;
    logic [DATA_WIDTH-1:0] qb;
    logic                  acc_a;
    logic                  acc_b;

    assign acc_a = ena && !rsta;
    assign acc_b = enb && !rsta;

    always_ff @(posedge clka) begin
        if (acc_a) qa <= mem[addra];
        if (acc_b) qb <= mem[addrb];
    end

    // B is applied first so A's later assignment wins on shared bytes
    always_ff @(posedge clka) begin
        for (int i = 0; i < NB; i++) begin
            if (acc_b && web[i]) begin
                mem[addrb][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                    dinb[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
            if (acc_a && wea[i]) begin
                mem[addra][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                    dina[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    bram_port_out #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .WRITE_MODE (WRITE_MODE),
        .OUT_REG    (OUT_REG)
    ) u_out_a (
        .clk  (clka),
        .rst  (rsta),
        .en   (ena),
        .we   (wea),
        .din  (dina),
        .q    (qa),
        .dout (douta),
        .val  (vala)
    );

    bram_port_out #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .WRITE_MODE (WRITE_MODE),
        .OUT_REG    (OUT_REG)
    ) u_out_b (
        .clk  (clka),
        .rst  (rsta),
        .en   (enb),
        .we   (web),
        .din  (dinb),
        .q    (qb),
        .dout (doutb),
        .val  (valb)
    );

endmodule

// File: doc/bram_tdp.md
# bram_tdp

Single-clock true-dual-port block RAM with per-byte write enables, a per-instance write mode (READ_FIRST / WRITE_FIRST / NO_CHANGE), an optional output pipeline register and read-valid strobes. It is the general-purpose on-chip buffer for datapath blocks that need two independent access ports, such as a producer and a consumer or two engines sharing a table. It sits directly under its users with no arbitration logic in front of it.

## Interface
- DATA_WIDTH, 16, word width; must be an integer multiple of BYTE_WIDTH
- ADDR_WIDTH, 9, address width; depth = 1<<ADDR_WIDTH
- BYTE_WIDTH, 8, write-enable granularity; NB = DATA_WIDTH/BYTE_WIDTH
- WRITE_MODE, bram_pkg::READ_FIRST, same-port read-during-write behaviour
- OUT_REG, 0, 1 adds an output pipeline stage
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clka  in  1  clock for both ports
- rsta  in  1  asynchronous active-high reset
- ena  in  1  port A access enable
- wea  in  NB  port A byte write enables; meaningful only when ena=1
- addra  in  ADDR_WIDTH  port A address
- dina  in  DATA_WIDTH  port A write data
- douta  out  DATA_WIDTH  port A read data
- vala  out  1  port A read data valid, one-cycle pulse
- enb, web, addrb, dinb, doutb, valb: the same signals for port B

## Operation
- Access types: ena=1 and wea=0 is a read; ena=1 and any bit of wea set is a write. ena=0 is idle, and douta/vala behave as described under Timing.
- Write: byte i of mem[addra] takes dina[i*BYTE_WIDTH +: BYTE_WIDTH] when wea[i]=1. Bytes with wea[i]=0 keep their old value.
- Same-port write result by WRITE_MODE:
  - READ_FIRST: douta = old word; vala=1.
  - WRITE_FIRST: douta = merged new word (enabled bytes new, other bytes old); vala=1.
  - NO_CHANGE: douta holds its previous value; vala=0.
- Cross-port read and write to the same address in the same cycle: the reader always gets the old word, whatever WRITE_MODE is set to.
- Write/write collision to the same address: port A wins on overlapping byte enables. Non-overlapping bytes from both ports are all written.
- Memory contents are not initialised and not cleared by reset.
- While rsta=1, all writes are suppressed and no reads are launched.

## Timing
- Read latency (enable cycle to data on douta with vala=1): 1 cycle with OUT_REG=0, 2 cycles with OUT_REG=1. Fully pipelined: one access per port per cycle.
- douta holds its last value when no new read completes. vala is 1 only in the cycle in which new data is presented.
- Reset values: douta=0, doutb=0, vala=0, valb=0, and all pipeline valid bits are 0.
- Reset mid-operation: reads in flight are discarded. Their data is never presented and their vala is never asserted. The first access after reset release completes with the normal latency.

## Structure
- bram_pkg holds:
  - typedef enum logic [1:0] {READ_FIRST, WRITE_FIRST, NO_CHANGE} bram_wmode_e
  - a function returning NB from DATA_WIDTH and BYTE_WIDTH
- Elaboration-time assertion: DATA_WIDTH % BYTE_WIDTH == 0.
- Sub-module bram_port_out is instantiated once per port. It contains:
  - the write-mode mux
  - the valid generation
  - the optional OUT_REG stage
  - the asynchronous reset of the output registers
- The memory array and the byte-merge write logic stay in the top-level module so that they infer as a true-dual-port block RAM.

## Test plan
- READ_FIRST, OUT_REG=0: write 0xBEEF to address 5 on port A, then read address 5 on port A. The write cycle presents the old word. The read shows douta=0xBEEF with vala=1 one cycle after the enable.
- Byte enables: mem[3]=0x1234, then port B writes 0xABCD with web=2'b01. A later read of address 3 returns 0x12CD.
- Same-port mode check on a write of 0x5555 to an address holding 0xAAAA:
  - WRITE_FIRST: douta=0x5555 with vala=1.
  - NO_CHANGE: douta is unchanged and vala=0.
- Collision: both ports write address 7 in one cycle, A with 0x1111 and wea=11, B with 0x2222 and web=11. The result is 0x1111. With wea=01 and web=10 instead, the result is 0x2211. A cross-port read of address 7 in the collision cycle returns the old word.
- OUT_REG=1: back-to-back reads of addresses 0, 1 and 2 produce data on cycles +2, +3 and +4, with vala held high for three consecutive cycles.
- Asserting rsta one cycle after a read issue (OUT_REG=1): douta drops to 0 and vala to 0 immediately, and no valid pulse follows. A write attempted while rsta=1 leaves the memory unchanged.
